// File: rtl/mips_ex_decode_unit.sv
// mips_ex_decode_unit: main control decode, ALU control decode and 32-bit ALU with a registered output stage
module mips_ex_decode_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic        o_reg_dst,
    output logic        o_branch,
    output logic        o_mem_read,
    output logic        o_mem_to_reg,
    output logic [1:0]  o_alu_op,
    output logic        o_mem_write,
    output logic        o_alu_src,
    output logic        o_reg_write,
    output logic [3:0]  o_alu_ctl,
    output logic [31:0] o_alu_result,
    output logic        o_zero,
    output logic        o_overflow,
    output logic        o_illegal
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm;
    logic        w_reg_dst;
    logic        w_branch;
    logic        w_mem_read;
    logic        w_mem_to_reg;
    logic [1:0]  w_alu_op;
    logic        w_mem_write;
    logic        w_alu_src;
    logic        w_reg_write;
    logic        w_ill_op;
    logic        w_ill_fn;
    logic [3:0]  w_alu_ctl;
    logic [31:0] w_imm_ext;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_overflow;

    logic        r_reg_dst;
    logic        r_branch;
    logic        r_mem_read;
    logic        r_mem_to_reg;
    logic [1:0]  r_alu_op;
    logic        r_mem_write;
    logic        r_alu_src;
    logic        r_reg_write;
    logic [3:0]  r_alu_ctl;
    logic [31:0] r_alu_result;
    logic        r_zero;
    logic        r_overflow;
    logic        r_illegal;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_shamt  = i_instr[10:6];
    assign w_imm    = i_instr[15:0];

    // Main control decode from the opcode; unknown opcodes leave every control bit low
    always_comb begin
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = 2'b00;
        w_ill_op     = 1'b0;
        case (w_opcode)
            6'b000000: begin w_reg_dst = 1'b1; w_reg_write = 1'b1; w_alu_op = 2'b10; end
            6'b100011: begin w_alu_src = 1'b1; w_mem_to_reg = 1'b1; w_reg_write = 1'b1; w_mem_read = 1'b1; end
            6'b101011: begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
            6'b000100: begin w_branch = 1'b1; w_alu_op = 2'b01; end
            6'b001000: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
            6'b001101: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 2'b11; end
            default:   w_ill_op = 1'b1;
        endcase
    end

    // ALU operation select from ALUOp, falling through to funct for R-type
    always_comb begin
        w_alu_ctl = ALU_ADD;
        w_ill_fn  = 1'b0;
        case (w_alu_op)
            2'b01: w_alu_ctl = ALU_SUB;
            2'b11: w_alu_ctl = ALU_OR;
            2'b10: begin
                case (w_funct)
                    6'b100000, 6'b100001: w_alu_ctl = ALU_ADD;
                    6'b100010, 6'b100011: w_alu_ctl = ALU_SUB;
                    6'b100100: w_alu_ctl = ALU_AND;
                    6'b100101: w_alu_ctl = ALU_OR;
                    6'b100110: w_alu_ctl = ALU_XOR;
                    6'b100111: w_alu_ctl = ALU_NOR;
                    6'b101010: w_alu_ctl = ALU_SLT;
                    6'b101011: w_alu_ctl = ALU_SLTU;
                    6'b000000: w_alu_ctl = ALU_SLL;
                    6'b000010: w_alu_ctl = ALU_SRL;
                    6'b000011: w_alu_ctl = ALU_SRA;
                    default: begin w_alu_ctl = ALU_BAD; w_ill_fn = 1'b1; end
                endcase
            end
            default: w_alu_ctl = ALU_ADD;
        endcase
    end

    // ori zero-extends its immediate; every other immediate user sign-extends
    assign w_imm_ext = (w_alu_op == 2'b11) ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};
    assign w_a       = i_rs_data;
    assign w_b       = w_alu_src ? w_imm_ext : i_rt_data;
    assign w_sum     = w_a + w_b;
    assign w_diff    = w_a - w_b;

    // ALU datapath; overflow is only meaningful for ADD and SUB
    always_comb begin
        w_result   = 32'h0;
        w_overflow = 1'b0;
        case (w_alu_ctl)
            ALU_ADD: begin
                w_result   = w_sum;
                w_overflow = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
            end
            ALU_SUB: begin
                w_result   = w_diff;
                w_overflow = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
            end
            ALU_AND:  w_result = w_a & w_b;
            ALU_OR:   w_result = w_a | w_b;
            ALU_XOR:  w_result = w_a ^ w_b;
            ALU_NOR:  w_result = ~(w_a | w_b);
            ALU_SLT:  w_result = {31'h0, $signed(w_a) < $signed(w_b)};
            ALU_SLTU: w_result = {31'h0, w_a < w_b};
            ALU_SLL:  w_result = w_b << w_shamt;
            ALU_SRL:  w_result = w_b >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(w_b) >>> w_shamt);
            default:  w_result = 32'h0;
        endcase
    end

    // Output stage: capture decode and ALU results every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_op     <= 2'b00;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_alu_ctl    <= 4'h0;
            r_alu_result <= 32'h0;
            r_zero       <= 1'b0;
            r_overflow   <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_reg_dst    <= w_reg_dst;
            r_branch     <= w_branch;
            r_mem_read   <= w_mem_read;
            r_mem_to_reg <= w_mem_to_reg;
            r_alu_op     <= w_alu_op;
            r_mem_write  <= w_mem_write;
            r_alu_src    <= w_alu_src;
            r_reg_write  <= w_reg_write;
            r_alu_ctl    <= w_alu_ctl;
            r_alu_result <= w_result;
            r_zero       <= (w_result == 32'h0);
            r_overflow   <= w_overflow;
            r_illegal    <= w_ill_op | w_ill_fn;
        end
    end

    assign o_reg_dst    = r_reg_dst;
    assign o_branch     = r_branch;
    assign o_mem_read   = r_mem_read;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_alu_op     = r_alu_op;
    assign o_mem_write  = r_mem_write;
    assign o_alu_src    = r_alu_src;
    assign o_reg_write  = r_reg_write;
    assign o_alu_ctl    = r_alu_ctl;
    assign o_alu_result = r_alu_result;
    assign o_zero       = r_zero;
    assign o_overflow   = r_overflow;
    assign o_illegal    = r_illegal;
endmodule

// File: tb/tb_mips_ex_decode_unit.sv
// tb_mips_ex_decode_unit: table-driven check of decode, ALU and reset behaviour
module tb_mips_ex_decode_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        zero, overflow, illegal;

    int n_cmp;
    int n_bad;

    // control bits ordered RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [8:0]  ctl;
        logic [3:0]  alu_ctl;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        ill;
    } vec_t;

    localparam logic [8:0] C_R    = 9'b100100010;
    localparam logic [8:0] C_LW   = 9'b011110000;
    localparam logic [8:0] C_SW   = 9'b010001000;
    localparam logic [8:0] C_BEQ  = 9'b000000101;
    localparam logic [8:0] C_ADDI = 9'b010100000;
    localparam logic [8:0] C_ORI  = 9'b010100011;
    localparam logic [8:0] C_NONE = 9'b000000000;

    vec_t vecs[22];

    mips_ex_decode_unit dut (
        .clk(clk), .rst_n(rst_n), .i_instr(instr), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .o_reg_dst(reg_dst), .o_branch(branch), .o_mem_read(mem_read), .o_mem_to_reg(mem_to_reg),
        .o_alu_op(alu_op), .o_mem_write(mem_write), .o_alu_src(alu_src), .o_reg_write(reg_write),
        .o_alu_ctl(alu_ctl), .o_alu_result(alu_result), .o_zero(zero), .o_overflow(overflow),
        .o_illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] i, input logic [31:0] a,
                                input logic [31:0] b, input logic [8:0] c, input logic [3:0] ac,
                                input logic [31:0] r, input logic z, input logic o, input logic il);
        vec_t v;
        v.name = name; v.instr = i; v.rs = a; v.rt = b; v.ctl = c; v.alu_ctl = ac;
        v.result = r; v.zero = z; v.ovf = o; v.ill = il;
        return v;
    endfunction

    function automatic logic [8:0] got_ctl();
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
    endfunction

    task automatic apply_and_check(input vec_t v);
        @(negedge clk);
        instr = v.instr; rs_data = v.rs; rt_data = v.rt;
        @(posedge clk);
        #1;
        check({v.name, ".ctl"},     64'(got_ctl()),   64'(v.ctl));
        check({v.name, ".alu_ctl"}, 64'(alu_ctl),     64'(v.alu_ctl));
        check({v.name, ".result"},  64'(alu_result),  64'(v.result));
        check({v.name, ".flags"},   64'({zero, overflow, illegal}), 64'({v.zero, v.ovf, v.ill}));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = mk("add",       32'h00000020, 32'd5,        32'd7,        C_R,    4'b0010, 32'd12,       0, 0, 0);
        vecs[1]  = mk("beq_eq",    32'h10000000, 32'h1234,     32'h1234,     C_BEQ,  4'b0110, 32'h0,        1, 0, 0);
        vecs[2]  = mk("beq_ne",    32'h10000000, 32'h1234,     32'h1235,     C_BEQ,  4'b0110, 32'hFFFFFFFF, 0, 0, 0);
        vecs[3]  = mk("lw_neg",    32'h8C00FFFC, 32'h100,      32'h0,        C_LW,   4'b0010, 32'hFC,       0, 0, 0);
        vecs[4]  = mk("ori_zext",  32'h3400FFFC, 32'h1,        32'h0,        C_ORI,  4'b0001, 32'h0000FFFD, 0, 0, 0);
        vecs[5]  = mk("add_ovf",   32'h00000020, 32'h7FFFFFFF, 32'h1,        C_R,    4'b0010, 32'h80000000, 0, 1, 0);
        vecs[6]  = mk("slt",       32'h0000002A, 32'hFFFFFFFF, 32'h1,        C_R,    4'b0111, 32'h1,        0, 0, 0);
        vecs[7]  = mk("sltu",      32'h0000002B, 32'hFFFFFFFF, 32'h1,        C_R,    4'b1011, 32'h0,        1, 0, 0);
        vecs[8]  = mk("sra",       32'h00000103, 32'h0,        32'h80000000, C_R,    4'b1010, 32'hF8000000, 0, 0, 0);
        vecs[9]  = mk("srl",       32'h00000102, 32'h0,        32'h80000000, C_R,    4'b1001, 32'h08000000, 0, 0, 0);
        vecs[10] = mk("sll31",     32'h000007C0, 32'h0,        32'h1,        C_R,    4'b1000, 32'h80000000, 0, 0, 0);
        vecs[11] = mk("bad_op",    32'hFC000000, 32'h3,        32'h4,        C_NONE, 4'b0010, 32'h7,        0, 0, 1);
        vecs[12] = mk("bad_fn",    32'h0000003F, 32'h3,        32'h4,        C_R,    4'b1111, 32'h0,        1, 0, 1);
        vecs[13] = mk("nop",       32'h00000000, 32'h5,        32'h0,        C_R,    4'b1000, 32'h0,        1, 0, 0);
        vecs[14] = mk("sub_ovf",   32'h00000022, 32'h80000000, 32'h1,        C_R,    4'b0110, 32'h7FFFFFFF, 0, 1, 0);
        vecs[15] = mk("sw",        32'hAC000008, 32'h10,       32'hDEAD,     C_SW,   4'b0010, 32'h18,       0, 0, 0);
        vecs[16] = mk("addi_neg",  32'h20008000, 32'h10000,    32'h0,        C_ADDI, 4'b0010, 32'h00008000, 0, 0, 0);
        vecs[17] = mk("and",       32'h00000024, 32'hF0F0,     32'hFF00,     C_R,    4'b0000, 32'hF000,     0, 0, 0);
        vecs[18] = mk("xor",       32'h00000026, 32'hFFFF0000, 32'h0F0F0F0F, C_R,    4'b1101, 32'hF0F00F0F, 0, 0, 0);
        vecs[19] = mk("nor",       32'h00000027, 32'h0,        32'h0,        C_R,    4'b1100, 32'hFFFFFFFF, 0, 0, 0);
        vecs[20] = mk("or",        32'h00000025, 32'h1,        32'h2,        C_R,    4'b0001, 32'h3,        0, 0, 0);
        vecs[21] = mk("subu",      32'h00000023, 32'h5,        32'h7,        C_R,    4'b0110, 32'hFFFFFFFE, 0, 0, 0);

        rst_n = 1'b0;
        instr = 32'h00000020; rs_data = 32'd5; rt_data = 32'd7;
        #12;
        check("reset_outputs", 64'({got_ctl(), alu_ctl, alu_result, zero, overflow, illegal}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) apply_and_check(vecs[i]);

        apply_and_check(vecs[0]);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", 64'({got_ctl(), alu_ctl, alu_result, zero, overflow, illegal}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_and_check(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
